vga_sprite_engine: RTL

Parametrised sprite compositor for the VGA path. It sits between the 640x480 timing generator and the RGB output pins, and moves a ROM-stored sprite once per frame, either under button control or in autonomous bounce mode. It clamps the sprite at the screen edges, computes the ROM address directly from the sprite position, and drops a transparent key colour to background. Output pixels are aligned to the timing generator's counters through a fixed pipeline.

---
 rtl/vga_pkg.sv | 86 ++++++++
 rtl/sprite_motion.sv | 114 +++++++++++
 rtl/vga_sprite_engine.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants, state/direction encodings and the per-axis motion
// helper used by the VGA sprite path.
package vga_pkg;

   // RGB 4:4:4 pixel width and the two special colours.
   localparam int PIX_W = 12;
   localparam logic [PIX_W-1:0] BG  = 12'h000;
   localparam logic [PIX_W-1:0] KEY = 12'hF0F;

   // Bit positions inside hit_edge = {top, bottom, left, right}.
   localparam int EDGE_TOP   = 3;
   localparam int EDGE_BOT   = 2;
   localparam int EDGE_LEFT  = 1;
   localparam int EDGE_RIGHT = 0;

   // Motion FSM: idle until a frame update, then one cycle to write position.
   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_STEP = 1'b1
   } motion_state_e;

   // Bounce direction per axis.
   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_e;

   // Result of advancing one axis by one update.
   typedef struct packed {
      logic [9:0] pos;
      dir_e       dir;
      logic       hit_lo;
      logic       hit_hi;
   } axis_res_t;

   // Advance one axis. In manual mode the inc/dec buttons choose the move
   // (both or neither means stay); in bounce mode the direction register does.
   // Arithmetic is 11-bit signed so a move below zero clamps instead of
   // wrapping. Landing on or beyond a bound clamps, flags the edge, and in
   // bounce mode reverses direction.
   function automatic axis_res_t axis_next(
      input logic [9:0]         pos,
      input dir_e               dir,
      input logic               bounce,
      input logic               inc_btn,
      input logic               dec_btn,
      input logic signed [10:0] step,
      input logic signed [10:0] max_pos
   );
      axis_res_t          r;
      logic signed [10:0] cur;
      logic signed [10:0] nxt;
      logic               move_inc;
      logic               move_dec;
      cur      = signed'({1'b0, pos});
      r.dir    = dir;
      r.hit_lo = 1'b0;
      r.hit_hi = 1'b0;
      move_inc = bounce ? (dir == DIR_INC) : (inc_btn & ~dec_btn);
      move_dec = bounce ? (dir == DIR_DEC) : (dec_btn & ~inc_btn);
      nxt      = cur;
      if (move_inc) begin
         nxt = cur + step;
      end
      if (move_dec) begin
         nxt = cur - step;
      end
      if (move_inc && (nxt >= max_pos)) begin
         nxt      = max_pos;
         r.hit_hi = 1'b1;
         if (bounce) begin
            r.dir = DIR_DEC;
         end
      end
      if (move_dec && (nxt <= 11'sd0)) begin
         nxt      = 11'sd0;
         r.hit_lo = 1'b1;
         if (bounce) begin
            r.dir = DIR_INC;
         end
      end
      r.pos = nxt[9:0];
      return r;
   endfunction

endpackage

// File: rtl/sprite_motion.sv
// Sprite position engine: frame divider, WAIT/STEP FSM, manual clamping and
// autonomous bounce. Position only changes in the STEP cycle, which follows
// the frame tick at the start of vertical blank.
module sprite_motion
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SPR_W     = 120,
   parameter int SPR_H     = 160,
   parameter int STEP      = 1,
   parameter int FRAME_DIV = 1,
   parameter int X0        = 260,
   parameter int Y0        = 160
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       mode,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [3:0] hit_edge
);

   localparam logic signed [10:0] MAX_X    = 11'(H_ACTIVE - SPR_W);
   localparam logic signed [10:0] MAX_Y    = 11'(V_ACTIVE - SPR_H);
   localparam logic signed [10:0] STEP_W   = 11'(STEP);
   localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

   motion_state_e state_q, state_d;
   logic [7:0]    div_q, div_d;
   logic [9:0]    pos_x_q, pos_x_d;
   logic [9:0]    pos_y_q, pos_y_d;
   dir_e          dir_x_q, dir_x_d;
   dir_e          dir_y_q, dir_y_d;
   logic          frame_tick;
   logic          update;
   axis_res_t     ax;
   axis_res_t     ay;

   // Detect the first blank line and divide frame ticks down to updates.
   always_comb begin
      frame_tick = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));
      div_d      = div_q;
      update     = 1'b0;
      if (frame_tick) begin
         if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            update = 1'b1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   // Motion FSM next state: one STEP cycle per update.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT: if (update) state_d = ST_STEP;
         ST_STEP: state_d = ST_WAIT;
         default: state_d = ST_WAIT;
      endcase
   end

   // Next position, direction and edge pulses; only applied while in STEP.
   always_comb begin
      ax       = axis_next(pos_x_q, dir_x_q, mode, right, left, STEP_W, MAX_X);
      ay       = axis_next(pos_y_q, dir_y_q, mode, down, up, STEP_W, MAX_Y);
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      hit_edge = 4'b0000;
      if (state_q == ST_STEP) begin
         pos_x_d              = ax.pos;
         pos_y_d              = ay.pos;
         dir_x_d              = ax.dir;
         dir_y_d              = ay.dir;
         hit_edge[EDGE_TOP]   = ay.hit_lo;
         hit_edge[EDGE_BOT]   = ay.hit_hi;
         hit_edge[EDGE_LEFT]  = ax.hit_lo;
         hit_edge[EDGE_RIGHT] = ax.hit_hi;
      end
   end

   // State registers with synchronous reset to the start position.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= ST_WAIT;
         div_q   <= 8'd0;
         pos_x_q <= 10'(X0);
         pos_y_q <= 10'(Y0);
         dir_x_q <= DIR_INC;
         dir_y_q <= DIR_INC;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
      end
   end

   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;

endmodule

// File: rtl/vga_sprite_engine.sv
// Sprite compositor: moves the sprite once per frame and overlays the ROM
// image on the background through a 3-stage pixel pipeline.
module vga_sprite_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SPR_W     = 120,
   parameter int SPR_H     = 160,
   parameter int ADDR_W    = 15,
   parameter int PIX_W     = vga_pkg::PIX_W,
   parameter int STEP      = 1,
   parameter int FRAME_DIV = 1,
   parameter int X0        = 260,
   parameter int Y0        = 160,
   parameter logic [PIX_W-1:0] KEY = vga_pkg::KEY,
   parameter logic [PIX_W-1:0] BG  = vga_pkg::BG
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              valid,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              up,
   input  logic              down,
   input  logic              left,
   input  logic              right,
   input  logic              mode,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic [PIX_W-1:0]  pix,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic [3:0]        hit_edge
);

   logic [9:0]        off_x;
   logic [9:0]        off_y;
   logic              in_area;
   logic [ADDR_W-1:0] lin_addr;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              area1_q, area1_d;
   logic              valid1_q, valid1_d;
   logic              area2_q, area2_d;
   logic              valid2_q, valid2_d;
   logic [PIX_W-1:0]  pix_q, pix_d;

   sprite_motion #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .SPR_W     (SPR_W),
      .SPR_H     (SPR_H),
      .STEP      (STEP),
      .FRAME_DIV (FRAME_DIV),
      .X0        (X0),
      .Y0        (Y0)
   ) u_motion (
      .pclk     (pclk),
      .rst      (rst),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .up       (up),
      .down     (down),
      .left     (left),
      .right    (right),
      .mode     (mode),
      .pos_x    (pos_x),
      .pos_y    (pos_y),
      .hit_edge (hit_edge)
   );

   // Stage 1: sprite-relative offsets (unsigned wrap makes left/above pixels
   // fail the compare), area flag and linear ROM address.
   always_comb begin
      off_x      = h_cnt - pos_x;
      off_y      = v_cnt - pos_y;
      in_area    = (off_x < 10'(SPR_W)) && (off_y < 10'(SPR_H));
      lin_addr   = ADDR_W'(off_y) * ADDR_W'(SPR_W) + ADDR_W'(off_x);
      rom_addr_d = in_area ? lin_addr : rom_addr_q;
      area1_d    = in_area;
      valid1_d   = valid;
   end

   // Stage 2 tracks the ROM read; stage 3 picks blank, sprite or background.
   always_comb begin
      area2_d  = area1_q;
      valid2_d = valid1_q;
      if (!valid2_q) begin
         pix_d = '0;
      end else if (area2_q && (rom_data != KEY)) begin
         pix_d = rom_data;
      end else begin
         pix_d = BG;
      end
   end

   // Pipeline registers; reset blanks the output until the pipe refills.
   always_ff @(posedge pclk) begin
      if (rst) begin
         rom_addr_q <= '0;
         area1_q    <= 1'b0;
         valid1_q   <= 1'b0;
         area2_q    <= 1'b0;
         valid2_q   <= 1'b0;
         pix_q      <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         area1_q    <= area1_d;
         valid1_q   <= valid1_d;
         area2_q    <= area2_d;
         valid2_q   <= valid2_d;
         pix_q      <= pix_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign pix      = pix_q;

endmodule
